// File: rtl/unidade_busca_pkg.sv
// Shared types for the instruction fetch unit: FSM states, default PC width
// and the instruction word.
package unidade_busca_pkg;
    localparam int LARG_PC    = 6;
    localparam int LARG_INSTR = 16;

    typedef logic [LARG_INSTR-1:0] palavra_t;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        BUSCANDO = 2'd1,
        CHEIO    = 2'd2
    } estado_t;
endpackage

// File: rtl/unidade_busca_if.sv
// Memory read port and decoder handshake of the fetch unit; master is the fetch side.
interface unidade_busca_if #(
    parameter int LARG_PC = unidade_busca_pkg::LARG_PC
);
    import unidade_busca_pkg::*;

    logic [LARG_PC-1:0] mem_end;
    logic               mem_req;
    palavra_t           mem_dado;
    logic               instr_valida;
    logic               instr_pronta;
    palavra_t           instrucao;
    logic [LARG_PC-1:0] instr_pc;

    modport master (
        output mem_end, mem_req, instr_valida, instrucao, instr_pc,
        input  mem_dado, instr_pronta
    );

    modport slave (
        input  mem_end, mem_req, instr_valida, instrucao, instr_pc,
        output mem_dado, instr_pronta
    );
endinterface

// File: rtl/fila_instrucao.sv
// Circular instruction buffer with flush; the head reads as zero while empty so
// stale entries never reach the decoder.
module fila_instrucao #(
    parameter int PROFUNDIDADE = 2,
    parameter int LARGURA      = 22,
    parameter int LARG_CONT    = $clog2(PROFUNDIDADE + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  logic [LARGURA-1:0]   dado,
    output logic [LARGURA-1:0]   cabeca,
    output logic [LARG_CONT-1:0] contagem
);
    localparam int LARG_PTR = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
    localparam logic [LARG_PTR-1:0]  PTR_ULTIMO = LARG_PTR'(PROFUNDIDADE - 1);
    localparam logic [LARG_CONT-1:0] CONT_CHEIA = LARG_CONT'(PROFUNDIDADE);

    logic [LARGURA-1:0]  entradas [PROFUNDIDADE];
    logic [LARG_PTR-1:0] ptr_leitura, ptr_escrita;
    logic                le, escreve;

    function automatic logic [LARG_PTR-1:0] avanca(input logic [LARG_PTR-1:0] p);
        return (p == PTR_ULTIMO) ? '0 : p + LARG_PTR'(1);
    endfunction

    assign le      = pop && (contagem != '0);
    assign escreve = push && ((contagem != CONT_CHEIA) || le);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_leitura <= '0;
            ptr_escrita <= '0;
            contagem    <= '0;
        end else if (flush) begin
            ptr_leitura <= '0;
            ptr_escrita <= '0;
            contagem    <= '0;
        end else begin
            if (escreve) ptr_escrita <= avanca(ptr_escrita);
            if (le)      ptr_leitura <= avanca(ptr_leitura);
            case ({escreve, le})
                2'b10:   contagem <= contagem + LARG_CONT'(1);
                2'b01:   contagem <= contagem - LARG_CONT'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (escreve && !flush) entradas[ptr_escrita] <= dado;
    end

    assign cabeca = (contagem != '0) ? entradas[ptr_leitura] : '0;
endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch unit: sequential PC reads with credit flow control, tagged
// responses buffered for the decoder, redirect flushes everything in flight.
// state    | meaning
// OCIOSO   | fetch disabled, no requests
// BUSCANDO | issuing requests while credit remains
// CHEIO    | buffer plus in-flight request occupy every entry
module unidade_busca #(
    parameter int LARG_PC      = unidade_busca_pkg::LARG_PC,
    parameter int PROFUNDIDADE = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               habilita,
    input  logic               desvio_valido,
    input  logic [LARG_PC-1:0] desvio_alvo,
    output logic [1:0]         ocupacao,
    unidade_busca_if.master    barramento
);
    import unidade_busca_pkg::*;

    localparam int LARG_CONT    = $clog2(PROFUNDIDADE + 1);
    localparam int LARG_ENTRADA = LARG_INSTR + LARG_PC;

    estado_t                 estado, estado_prox;
    logic [LARG_PC-1:0]      pc_busca, tag_voo;
    logic                    em_voo, credito, pop, push, req;
    logic [LARG_CONT-1:0]    contagem;
    logic [LARG_ENTRADA-1:0] cabeca;

    assign pop     = barramento.instr_valida && barramento.instr_pronta;
    // A response landing during a redirect belongs to the old path.
    assign push    = em_voo && !desvio_valido;
    assign credito = (int'(contagem) + int'(em_voo) - int'(pop)) < PROFUNDIDADE;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_busca <= '0;
            tag_voo  <= '0;
            em_voo   <= 1'b0;
        end else begin
            em_voo  <= req;
            tag_voo <= pc_busca;
            if (desvio_valido) pc_busca <= desvio_alvo;
            else if (req)      pc_busca <= pc_busca + LARG_PC'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= OCIOSO;
        else        estado <= estado_prox;
    end

    always_comb begin
        estado_prox = estado;
        if (!habilita) begin
            estado_prox = OCIOSO;
        end else if (desvio_valido) begin
            estado_prox = BUSCANDO;
        end else begin
            case (estado)
                OCIOSO:   estado_prox = BUSCANDO;
                BUSCANDO: if (!credito) estado_prox = CHEIO;
                CHEIO:    if (credito)  estado_prox = BUSCANDO;
                default:  estado_prox = OCIOSO;
            endcase
        end
    end

    // Gating on the registered state keeps mem_req low throughout reset.
    always_comb begin
        req = 1'b0;
        if ((estado != OCIOSO) && habilita && !desvio_valido && credito) req = 1'b1;
    end

    fila_instrucao #(
        .PROFUNDIDADE (PROFUNDIDADE),
        .LARGURA      (LARG_ENTRADA),
        .LARG_CONT    (LARG_CONT)
    ) u_fila (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (desvio_valido),
        .dado     ({tag_voo, barramento.mem_dado}),
        .cabeca   (cabeca),
        .contagem (contagem)
    );

    assign barramento.mem_req      = req;
    assign barramento.mem_end      = pc_busca;
    assign barramento.instr_valida = (contagem != '0);
    assign {barramento.instr_pc, barramento.instrucao} = cabeca;
    assign ocupacao = 2'(contagem);
endmodule
